// File: rtl/spi_mem_ctrl.sv
// Single-port memory controller sitting between an SPI slave's rx word bus and its tx loader.
// Decodes 2-bit-tagged command words, auto-increments pointers in bursts and hands read data out over a valid/ready pair.
module spi_mem_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] din,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              cmd_err,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    localparam int         DEPTH       = 1 << ADDR_W;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] payload;
    logic              rd_req;
    logic              rd_accept;

    assign cmd     = din[DATA_W+1:DATA_W];
    assign payload = din[DATA_W-1:0];
    assign addr    = din[ADDR_W-1:0];
    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;

    // A read is taken when nothing is pending, or when the pending word is consumed this same cycle.
    assign rd_req    = rx_valid && (cmd == CMD_RD_DATA);
    assign rd_accept = rd_req && ((state == IDLE) || tx_ready);

    // Memory array has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rx_valid && (cmd == CMD_WR_DATA))
            mem[wr_ptr] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dout     <= '0;
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            cmd_err <= 1'b0;

            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_ptr <= addr;
                    CMD_WR_DATA: if (AUTO_INC) wr_ptr <= wr_ptr + ADDR_W'(1);
                    CMD_RD_ADDR: rd_ptr <= addr;
                    default: ;
                endcase
            end

            if (rd_accept && AUTO_INC)
                rd_ptr <= rd_ptr + ADDR_W'(1);

            case (state)
                IDLE: begin
                    if (rd_accept) begin
                        dout     <= mem[rd_ptr];
                        tx_valid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // A read arriving while the consumer stalls is dropped and flagged.
                    if (rd_accept) begin
                        dout <= mem[rd_ptr];
                    end else if (rd_req) begin
                        cmd_err <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: directed vector table, hand-written reset/narrow-config sequences,
// then randomized traffic checked against a transaction-level model of the memory and handshake.
module tb_spi_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [9:0]  din;
    logic        tx_ready;
    logic [7:0]  dout;
    logic        tx_valid;
    logic        cmd_err;
    logic [7:0]  wr_addr;
    logic [7:0]  rd_addr;

    logic        rx_valid6;
    logic [17:0] din6;
    logic        tx_ready6;
    logic [15:0] dout6;
    logic        tx_valid6;
    logic        cmd_err6;
    logic [3:0]  wr_addr6;
    logic [3:0]  rd_addr6;

    int vectorsApplied = 0;
    int miscompares    = 0;

    spi_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .tx_ready(tx_ready),
        .dout(dout), .tx_valid(tx_valid), .cmd_err(cmd_err), .wr_addr(wr_addr), .rd_addr(rd_addr)
    );

    spi_mem_ctrl #(.DATA_W(16), .ADDR_W(4), .AUTO_INC(1'b0)) dut6 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid6), .din(din6), .tx_ready(tx_ready6),
        .dout(dout6), .tx_valid(tx_valid6), .cmd_err(cmd_err6), .wr_addr(wr_addr6), .rd_addr(rd_addr6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rxv;
        logic [9:0] d;
        bit         rdy;
        bit         expValid;
        logic [7:0] expDout;
        bit         expErr;
        logic [7:0] expWr;
        logic [7:0] expRd;
    } vec_t;

    vec_t vecs [16];

    // Reference model: plain memory array, integer pointers and a "word pending" flag.
    logic [7:0] modelMem [256];
    int         modelWp;
    int         modelRp;
    bit         modelValid;
    bit         modelErr;
    logic [7:0] modelDout;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorsApplied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit rxv, input logic [9:0] d, input bit rdy);
        rx_valid = rxv;
        din      = d;
        tx_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic applyWideStimulus(input bit rxv, input logic [17:0] d, input bit rdy);
        rx_valid6 = rxv;
        din6      = d;
        tx_ready6 = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        modelWp    = 0;
        modelRp    = 0;
        modelValid = 1'b0;
        modelErr   = 1'b0;
        modelDout  = 8'h00;
    endtask

    task automatic modelStep(input bit rxv, input logic [9:0] d, input bit rdy);
        bit pending;
        pending  = modelValid;
        modelErr = 1'b0;
        if (pending && rdy)
            modelValid = 1'b0;
        if (rxv) begin
            case (d[9:8])
                2'd0: modelWp = int'(d[7:0]);
                2'd1: begin
                    modelMem[modelWp] = d[7:0];
                    modelWp = (modelWp + 1) % 256;
                end
                2'd2: modelRp = int'(d[7:0]);
                default: begin
                    if (!pending || rdy) begin
                        modelDout  = modelMem[modelRp];
                        modelValid = 1'b1;
                        modelRp    = (modelRp + 1) % 256;
                    end else begin
                        modelErr = 1'b1;
                    end
                end
            endcase
        end
    endtask

    task automatic runModelCycle(input bit rxv, input logic [9:0] d, input bit rdy);
        applyStimulus(rxv, d, rdy);
        modelStep(rxv, d, rdy);
        checkOutput("rnd.tx_valid", 32'(tx_valid), 32'(modelValid));
        checkOutput("rnd.dout",     32'(dout),     32'(modelDout));
        checkOutput("rnd.cmd_err",  32'(cmd_err),  32'(modelErr));
        checkOutput("rnd.wr_addr",  32'(wr_addr),  32'(modelWp));
        checkOutput("rnd.rd_addr",  32'(rd_addr),  32'(modelRp));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        din       = '0;
        tx_ready  = 1'b0;
        rx_valid6 = 1'b0;
        din6      = '0;
        tx_ready6 = 1'b0;

        //          rxv  din            rdy  valid dout  err  wr     rd
        vecs[0]  = '{1, {2'b00, 8'h10}, 0,   0,    8'h00, 0,  8'h10, 8'h00};
        vecs[1]  = '{1, {2'b01, 8'hA5}, 0,   0,    8'h00, 0,  8'h11, 8'h00};
        vecs[2]  = '{1, {2'b10, 8'h10}, 0,   0,    8'h00, 0,  8'h11, 8'h10};
        vecs[3]  = '{1, {2'b11, 8'h00}, 0,   1,    8'hA5, 0,  8'h11, 8'h11};
        vecs[4]  = '{0, {2'b00, 8'h00}, 1,   0,    8'hA5, 0,  8'h11, 8'h11};
        vecs[5]  = '{1, {2'b00, 8'hFE}, 0,   0,    8'hA5, 0,  8'hFE, 8'h11};
        vecs[6]  = '{1, {2'b01, 8'h11}, 0,   0,    8'hA5, 0,  8'hFF, 8'h11};
        vecs[7]  = '{1, {2'b01, 8'h22}, 0,   0,    8'hA5, 0,  8'h00, 8'h11};
        vecs[8]  = '{1, {2'b01, 8'h33}, 0,   0,    8'hA5, 0,  8'h01, 8'h11};
        vecs[9]  = '{1, {2'b10, 8'hFE}, 1,   0,    8'hA5, 0,  8'h01, 8'hFE};
        vecs[10] = '{1, {2'b11, 8'h00}, 1,   1,    8'h11, 0,  8'h01, 8'hFF};
        vecs[11] = '{1, {2'b11, 8'h00}, 1,   1,    8'h22, 0,  8'h01, 8'h00};
        vecs[12] = '{1, {2'b11, 8'h00}, 1,   1,    8'h33, 0,  8'h01, 8'h01};
        vecs[13] = '{1, {2'b11, 8'h00}, 0,   1,    8'h33, 1,  8'h01, 8'h01};
        vecs[14] = '{0, {2'b00, 8'h00}, 0,   1,    8'h33, 0,  8'h01, 8'h01};
        vecs[15] = '{0, {2'b00, 8'h00}, 1,   0,    8'h33, 0,  8'h01, 8'h01};

        #12;
        checkOutput("rst.tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst.dout",     32'(dout),     32'd0);
        checkOutput("rst.wr_addr",  32'(wr_addr),  32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst.cmd_err",  32'(cmd_err),  32'd0);
        checkOutput("rst.rd_addr",  32'(rd_addr),  32'd0);

        // Narrow, non-incrementing instance: repeated writes land on the same address.
        applyWideStimulus(1'b1, {2'b00, 16'h0003}, 1'b0);
        applyWideStimulus(1'b1, {2'b01, 16'h1234}, 1'b0);
        checkOutput("w6.wr_addr_a", 32'(wr_addr6), 32'h3);
        applyWideStimulus(1'b1, {2'b01, 16'hBEEF}, 1'b0);
        checkOutput("w6.wr_addr_b", 32'(wr_addr6), 32'h3);
        applyWideStimulus(1'b1, {2'b10, 16'h0003}, 1'b0);
        applyWideStimulus(1'b1, {2'b11, 16'h0000}, 1'b0);
        checkOutput("w6.dout",      32'(dout6),     32'hBEEF);
        checkOutput("w6.tx_valid",  32'(tx_valid6), 32'd1);
        checkOutput("w6.rd_addr",   32'(rd_addr6),  32'h3);
        applyWideStimulus(1'b0, 18'h0, 1'b1);
        checkOutput("w6.release",   32'(tx_valid6), 32'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rxv, vecs[i].d, vecs[i].rdy);
            checkOutput($sformatf("vec%0d.tx_valid", i), 32'(tx_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d.dout", i),     32'(dout),     32'(vecs[i].expDout));
            checkOutput($sformatf("vec%0d.cmd_err", i),  32'(cmd_err),  32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d.wr_addr", i),  32'(wr_addr),  32'(vecs[i].expWr));
            checkOutput($sformatf("vec%0d.rd_addr", i),  32'(rd_addr),  32'(vecs[i].expRd));
        end

        // Reset while a word is pending, then confirm memory survived.
        applyStimulus(1'b1, {2'b10, 8'h10}, 1'b0);
        applyStimulus(1'b1, {2'b11, 8'h00}, 1'b0);
        checkOutput("hold.tx_valid", 32'(tx_valid), 32'd1);
        checkOutput("hold.dout",     32'(dout),     32'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async.tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("async.wr_addr",  32'(wr_addr),  32'd0);
        checkOutput("async.rd_addr",  32'(rd_addr),  32'd0);
        checkOutput("async.dout",     32'(dout),     32'd0);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, {2'b10, 8'h10}, 1'b0);
        applyStimulus(1'b1, {2'b11, 8'h00}, 1'b0);
        checkOutput("survive.dout",     32'(dout),     32'hA5);
        checkOutput("survive.tx_valid", 32'(tx_valid), 32'd1);

        // Randomized phase: fill the whole memory so the model knows every word, then mix traffic.
        applyStimulus(1'b0, 10'h0, 1'b0);
        doReset();
        modelReset();
        runModelCycle(1'b1, {2'b00, 8'h00}, 1'b0);
        for (int i = 0; i < 256; i++)
            runModelCycle(1'b1, {2'b01, 8'($urandom)}, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 600; i++)
            runModelCycle($urandom_range(0, 3) != 0, 10'($urandom), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
